i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C slave exposing an 8-entry x 8-bit register map on an open-drain SDA/SCL bus.
//  Registers 0-3 are read/write and drive output ports; registers 4-7 are read-only
//  and sample input ports. Sits at the board-level bus, beside an I2C master, in the system clock domain.
// PARAMETERS
//  I2C_ADDR     7'h3C  7-bit device address matched after START
//  DEB_LEN      3      glitch-filter length in clk cycles for SCL/SDA (consecutive equal samples)
//  SDA_DEL_LEN  4      clk cycles after SCL falling edge before SDA output may change
// PORTS
//  clk     in     1  system clock (>= 20x SCL rate)
//  rst     in     1  asynchronous reset, active-low
//  sda     inout  1  I2C data, open-drain: drive 0 or release to 'z'
//  scl     in     1  I2C clock (no clock stretching)
//  myReg0..myReg3  out  8  R/W registers 0-3
//  myReg4..myReg7  in   8  read-only values returned for registers 4-7
// BEHAVIOUR
//  - Reset (rst=0, async): myReg0-3=8'h00, register pointer=0, FSM=IDLE, SDA released.
//  - Inputs: 2-flop synchronise SCL/SDA, then filter: level changes only after DEB_LEN equal samples.
//  - START = filtered SDA falls while SCL high; STOP = SDA rises while SCL high. Detected in any
//    state; STOP -> IDLE; START (incl. repeated) -> RX_ADDR, bit counter cleared.
//  - Bits sampled on SCL rising edge, MSB first. SDA driven/released SDA_DEL_LEN clks after SCL falls.
//  - FSM: IDLE, RX_ADDR, ACK_ADDR, RX_REGADDR, ACK_REGADDR, RX_DATA, ACK_DATA, TX_DATA, RX_MACK.
//    IDLE -START-> RX_ADDR. After 8 bits: if addr[7:1]==I2C_ADDR -> ACK_ADDR (drive 0 for the 9th
//    clock), else release and wait in IDLE for next START/STOP.
//    ACK_ADDR: R/W=0 -> RX_REGADDR; R/W=1 -> TX_DATA (load byte at pointer).
//    RX_REGADDR: 8 bits -> pointer=byte[2:0], ACK -> RX_DATA.
//    RX_DATA: 8 bits -> write reg[pointer] if pointer<4 (4-7 ignored, still ACKed), ACK,
//    pointer+1 (wrap 7->0), stay in RX_DATA.
//    TX_DATA: shift out reg[pointer] (0-3 internal value, 4-7 myRegN input, captured at byte start);
//    release SDA on 9th clock -> RX_MACK; sample: ACK(0) -> pointer+1 (wrap), next byte;
//    NACK(1) -> IDLE (SDA released) until START/STOP.
//  - Register writes take effect on the clk after the 8th data bit is sampled.
//  - Pointer persists across transactions (read after write-of-pointer reads from that pointer).
//  - SDA never driven while SCL high except during ACK/data bit hold; never drive 1.
// STRUCTURE
//  Package i2c_slave_pkg: FSM state enum, reg count (8), pointer width (3).
//  Sub-module i2c_slave_regs: register file (0-3 storage, 4-7 mux from inputs), write strobe,
//  read data by pointer. Top holds filter, START/STOP detect, FSM, shift registers, SDA driver.
// TESTING  (bench: clk 50 MHz, opencores i2c_master_top via Wishbone model, pullups on SDA/SCL)
//  1 Reset: rst=0 -> myReg0-3=00, sda='z'; bus idle high.
//  2 Write: START,78h(3C+W),00h,AAh,55h,STOP -> all ACKed; myReg0=AAh, myReg1=55h.
//  3 Read-only: myReg4..7=12h,34h,56h,78h; START,78h,04h,Sr,79h, read 4 bytes (ACK,ACK,ACK,NACK),STOP
//    -> master receives 12h,34h,56h,78h.
//  4 Wrap/ignore: write ptr 07h then data 11h,22h -> reg7 unchanged (still reads 78h), myReg0=22h;
//    read from ptr 07h two bytes -> 78h,22h.
//  5 Wrong address: START,A0h -> no ACK (master sees RxACK=1), no register change.
//  6 Async reset mid-write (after reg-address byte) -> SDA released immediately, myReg0-3=00,
//    next full transaction completes normally.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared FSM state encoding and register-map sizing for the I2C slave
package i2c_slave_pkg;
    localparam int REG_COUNT = 8;
    localparam int RW_COUNT  = 4;
    localparam int PTR_W     = 3;

    typedef enum logic [3:0] {
        IDLE,
        RX_ADDR,
        ACK_ADDR,
        RX_REGADDR,
        ACK_REGADDR,
        RX_DATA,
        ACK_DATA,
        TX_DATA,
        RX_MACK
    } state_t;
endpackage

// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: 8-entry register map, entries 0-3 stored, entries 4-7 taken from inputs
//  clk, rst    : system clock, asynchronous active-low reset
//  we          : write strobe (writes to entries 4-7 are dropped)
//  addr, wdata : register pointer and write data
//  rdata       : value of the entry selected by addr
//  rw_regs     : stored entries 0-3
//  ro_regs     : read-only entries 4-7
module i2c_slave_regs
    import i2c_slave_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we,
    input  logic [PTR_W-1:0]                 addr,
    input  logic [7:0]                       wdata,
    output logic [7:0]                       rdata,
    output logic [RW_COUNT-1:0][7:0]         rw_regs,
    input  logic [REG_COUNT-RW_COUNT-1:0][7:0] ro_regs
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) rw_regs <= '0;
        else if (we && !addr[2]) rw_regs[addr[1:0]] <= wdata;

    assign rdata = addr[2] ? ro_regs[addr[1:0]] : rw_regs[addr[1:0]];
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C slave exposing an 8 x 8-bit register map on an open-drain bus
//  clk            : system clock (>= 20x SCL rate)
//  rst            : asynchronous active-low reset
//  sda            : I2C data, only ever pulled low or released
//  scl            : I2C clock (no stretching)
//  myReg0..myReg3 : read/write registers 0-3
//  myReg4..myReg7 : values returned for read-only registers 4-7
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h3C,
    parameter int         DEB_LEN     = 3,
    parameter int         SDA_DEL_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        sda,
    input  logic       scl,
    output logic [7:0] myReg0,
    output logic [7:0] myReg1,
    output logic [7:0] myReg2,
    output logic [7:0] myReg3,
    input  logic [7:0] myReg4,
    input  logic [7:0] myReg5,
    input  logic [7:0] myReg6,
    input  logic [7:0] myReg7
);
    localparam int DW  = $clog2(DEB_LEN + 1);
    localparam int DLW = $clog2(SDA_DEL_LEN + 1);

    // bit 1 = SCL, bit 0 = SDA
    logic [1:0]       s1, s2, filt, filt_q;
    logic [DW-1:0]    fcnt [2];
    state_t           state, state_n;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift, rdata;
    logic [PTR_W-1:0] ptr;
    logic             rw, ld, oe, we, drive;
    logic [DLW-1:0]   del_cnt;
    logic [RW_COUNT-1:0][7:0] rw_regs;

    // A line only changes its filtered level after DEB_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1      <= '1;
            s2      <= '1;
            filt    <= '1;
            filt_q  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            s1     <= {scl, sda};
            s2     <= s1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++)
                if (s2[i] == filt[i]) fcnt[i] <= '0;
                else if (fcnt[i] == DW'(DEB_LEN - 1)) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else fcnt[i] <= fcnt[i] + 1'b1;
        end

    wire scl_rise = filt[1] & ~filt_q[1];
    wire scl_fall = ~filt[1] & filt_q[1];
    wire start_c  = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
    wire stop_c   = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];
    wire [7:0] byte_in = {shift[6:0], filt[0]};
    wire last     = bit_cnt == 3'd7;
    wire is_ack   = state inside {ACK_ADDR, ACK_REGADDR, ACK_DATA, RX_MACK};

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        we      = 1'b0;
        if (stop_c) state_n = IDLE;
        else if (start_c) state_n = RX_ADDR;
        else if (scl_rise)
            case (state)
                RX_ADDR:     if (last) state_n = (byte_in[7:1] == I2C_ADDR) ? ACK_ADDR : IDLE;
                ACK_ADDR:    state_n = rw ? TX_DATA : RX_REGADDR;
                RX_REGADDR:  if (last) state_n = ACK_REGADDR;
                ACK_REGADDR: state_n = RX_DATA;
                RX_DATA:     if (last) begin
                    state_n = ACK_DATA;
                    we      = 1'b1;
                end
                ACK_DATA:    state_n = RX_DATA;
                TX_DATA:     if (last) state_n = RX_MACK;
                RX_MACK:     state_n = filt[0] ? IDLE : TX_DATA;
                default:     state_n = state;
            endcase
        // Level SDA should take once the post-fall delay expires.
        drive = (state inside {ACK_ADDR, ACK_REGADDR, ACK_DATA}) || (state == TX_DATA && !shift[7]);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            ld      <= 1'b0;
            oe      <= 1'b0;
            del_cnt <= '0;
        end else begin
            ld <= state_n == TX_DATA && state != TX_DATA;
            // Byte is loaded one clk after entering TX_DATA so rdata reflects the updated pointer.
            if (ld) shift <= rdata;
            else if (scl_rise) shift <= byte_in;
            if (start_c || stop_c) bit_cnt <= '0;
            else if (scl_rise) bit_cnt <= is_ack ? 3'd0 : bit_cnt + 1'b1;
            if (state == RX_ADDR && scl_rise && last) rw <= filt[0];
            if (state == RX_REGADDR && scl_rise && last) ptr <= byte_in[2:0];
            if (we || (state == RX_MACK && scl_rise && !filt[0])) ptr <= ptr + 1'b1;
            if (start_c || stop_c || state_n == IDLE) begin
                oe      <= 1'b0;
                del_cnt <= '0;
            end else if (scl_fall) del_cnt <= DLW'(SDA_DEL_LEN);
            else if (del_cnt != '0) begin
                del_cnt <= del_cnt - 1'b1;
                if (del_cnt == DLW'(1)) oe <= drive;
            end
        end

    assign sda = oe ? 1'b0 : 1'bz;

    i2c_slave_regs u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr    (ptr),
        .wdata   (byte_in),
        .rdata   (rdata),
        .rw_regs (rw_regs),
        .ro_regs ({myReg7, myReg6, myReg5, myReg4})
    );

    assign {myReg3, myReg2, myReg1, myReg0} = rw_regs;
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave against a register-map model
module tb_i2c_slave;
    localparam int         Q    = 200;
    localparam logic [6:0] ADDR = 7'h3C;

    logic       clk = 1'b0, rst = 1'b0, scl = 1'b1, m_low = 1'b0;
    wire        sda;
    logic [7:0] my0, my1, my2, my3;
    logic [7:0] my4 = 8'h00, my5 = 8'h00, my6 = 8'h00, my7 = 8'h00;
    int         total = 0, bad = 0;
    logic [7:0] mreg [8];
    logic [2:0] mptr = 3'd0;
    logic [7:0] wq [$];
    logic       a;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    always #10 clk = ~clk;

    i2c_slave dut (
        .clk(clk), .rst(rst), .sda(sda), .scl(scl),
        .myReg0(my0), .myReg1(my1), .myReg2(my2), .myReg3(my3),
        .myReg4(my4), .myReg5(my5), .myReg6(my6), .myReg7(my7)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic bus();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic bstart();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bstop();
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
    endtask

    task automatic wbit(input logic b);
        m_low = !b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        m_low = 1'b0; #Q; scl = 1'b1; #Q; b = bus(); #Q; scl = 1'b0; #Q;
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            rbit(b);
            d = {d[6:0], b};
        end
        wbit(nack);
    endtask

    task automatic set_ro(input logic [7:0] v4, v5, v6, v7);
        my4 = v4; my5 = v5; my6 = v6; my7 = v7;
        mreg[4] = v4; mreg[5] = v5; mreg[6] = v6; mreg[7] = v7;
    endtask

    task automatic check_rw(input string tag);
        check({tag, "/r0"}, my0, mreg[0]);
        check({tag, "/r1"}, my1, mreg[1]);
        check({tag, "/r2"}, my2, mreg[2]);
        check({tag, "/r3"}, my3, mreg[3]);
    endtask

    // Writes wq starting at register p; entries 4-7 are ignored but still acknowledged.
    task automatic do_write(input string tag, input logic [2:0] p);
        logic k;
        bstart();
        wbyte({ADDR, 1'b0}, k); check({tag, "/wa_ack"}, 8'(k), 8'h00);
        wbyte({5'b0, p}, k);    check({tag, "/wp_ack"}, 8'(k), 8'h00);
        mptr = p;
        foreach (wq[i]) begin
            wbyte(wq[i], k); check($sformatf("%s/wd%0d_ack", tag, i), 8'(k), 8'h00);
            if (mptr < 3'd4) mreg[mptr] = wq[i];
            mptr = mptr + 3'd1;
        end
        bstop();
        check_rw(tag);
    endtask

    // Reads n bytes, optionally setting the pointer first with a repeated START.
    task automatic do_read(input string tag, input logic setp, input logic [2:0] p, input int n);
        logic k;
        logic [7:0] d;
        bstart();
        if (setp) begin
            wbyte({ADDR, 1'b0}, k); check({tag, "/sa_ack"}, 8'(k), 8'h00);
            wbyte({5'b0, p}, k);    check({tag, "/sp_ack"}, 8'(k), 8'h00);
            mptr = p;
            bstart();
        end
        wbyte({ADDR, 1'b1}, k); check({tag, "/ra_ack"}, 8'(k), 8'h00);
        for (int i = 0; i < n; i++) begin
            rbyte(i == n - 1, d);
            check($sformatf("%s/rd%0d", tag, i), d, mreg[mptr]);
            if (i != n - 1) mptr = mptr + 3'd1;
        end
        bstop();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
        #100;
        check_rw("reset");
        check("reset/sda", 8'(sda), 8'h01);
        #40 rst = 1'b1;
        #200;

        wq = '{8'hAA, 8'h55};
        do_write("write", 3'd0);

        set_ro(8'h12, 8'h34, 8'h56, 8'h78);
        do_read("ro", 1'b1, 3'd4, 4);

        wq = '{8'h11, 8'h22};
        do_write("wrap", 3'd7);
        do_read("wrap", 1'b1, 3'd7, 2);

        bstart();
        wbyte(8'hA0, a); check("badaddr/ack", 8'(a), 8'h01);
        wbyte(8'h00, a); check("badaddr/ack2", 8'(a), 8'h01);
        bstop();
        check_rw("badaddr");

        do_read("persist", 1'b0, 3'd0, 2);

        for (int it = 0; it < 4; it++) begin
            set_ro(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            wq.delete();
            repeat ($urandom_range(1, 3)) wq.push_back(8'($urandom));
            do_write($sformatf("rnd%0d", it), 3'($urandom));
            do_read($sformatf("rnd%0d", it), 1'b1, 3'($urandom), int'($urandom_range(1, 4)));
            do_read($sformatf("rnd%0d/cont", it), 1'b0, 3'd0, 1);
        end

        wq = '{8'hC3, 8'h3C, 8'h5A, 8'hA5};
        do_write("prefill", 3'd0);
        bstart();
        wbyte({ADDR, 1'b0}, a);
        for (int i = 7; i >= 0; i--) wbit(i == 0);
        m_low = 1'b0; #Q; scl = 1'b1; #Q;
        check("midrst/ack", 8'(bus()), 8'h00);
        rst = 1'b0;
        #20;
        check("midrst/sda", 8'(sda), 8'h01);
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mptr = 3'd0;
        check_rw("midrst");
        scl = 1'b0; #Q;
        rst = 1'b1; #Q;
        bstop();

        wq = '{8'($urandom), 8'($urandom)};
        do_write("post", 3'd2);
        do_read("post", 1'b1, 3'd1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
